// File: rtl/bp_update_queue.sv
// bp_update_queue: FIFO of resolved branch outcomes that drains one entry per
// cycle into the branch predictor cache update port, with a one-cycle bubble
// after any write that evicts a line.
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready  resolved-branch handshake; in_pc, in_taken, in_target payload
//   we, update_pc, branch_taken, wb_addr  registered cache write port
//   evict  cache reports that the current write displaced a valid line
//   empty  nothing queued and no write in flight
//   wr_count, evict_count  saturating statistics (only with BPQ_STATS_EN)
//
// Optional feature macro: BPQ_STATS_EN adds the statistics counters.
module bp_update_queue #(
   parameter int PC_W  = 10,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [PC_W-1:0] in_pc,
   input  logic            in_taken,
   input  logic [PC_W-1:0] in_target,
   output logic            we,
   output logic [PC_W-1:0] update_pc,
   output logic            branch_taken,
   output logic [PC_W-1:0] wb_addr,
   input  logic            evict,
   output logic            empty
`ifdef BPQ_STATS_EN
   ,
   output logic [15:0]     wr_count,
   output logic [15:0]     evict_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WRITE, BUBBLE} state_t;
   state_t          state;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic [PC_W-1:0] pc_mem [DEPTH];
   logic            taken_mem [DEPTH];
   logic [PC_W-1:0] tgt_mem [DEPTH];
   logic            push, pop;
   assign in_ready = count < (AW+1)'(DEPTH);
   assign push     = in_valid && in_ready;
   // An evicting write blocks the pop, so the following cycle is the bubble;
   // leaving the bubble pops straight away, making an eviction cost one cycle.
   assign pop      = count != '0 && !(state == WRITE && evict);
   assign empty    = count == '0 && state == IDLE;
   always_ff @(posedge clk)
      if (push) begin
         pc_mem[wr_ptr]    <= in_pc;
         taken_mem[wr_ptr] <= in_taken;
         tgt_mem[wr_ptr]   <= in_target;
      end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         we           <= 1'b0;
         update_pc    <= '0;
         branch_taken <= 1'b0;
         wb_addr      <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + (AW+1)'(push) - (AW+1)'(pop);
         we     <= pop;
         state  <= pop ? WRITE : (state == WRITE && evict) ? BUBBLE : IDLE;
         if (pop) begin
            update_pc    <= pc_mem[rd_ptr];
            branch_taken <= taken_mem[rd_ptr];
            wb_addr      <= tgt_mem[rd_ptr];
         end
      end
`ifdef BPQ_STATS_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_count    <= '0;
         evict_count <= '0;
      end else begin
         wr_count    <= wr_count + 16'(we && wr_count != 16'hFFFF);
         evict_count <= evict_count + 16'(we && evict && evict_count != 16'hFFFF);
      end
`endif
endmodule

// File: tb/tb_bp_update_queue.sv
// tb_bp_update_queue: vector table, hand sequences and random traffic checked against a queue model.
module tb_bp_update_queue;
   localparam int PC_W = 10, DEPTH = 4;
   logic clk = 0, rst = 0, in_valid = 0, in_taken = 0, evict = 0;
   logic [PC_W-1:0] in_pc = '0, in_target = '0;
   logic in_ready, we, branch_taken, empty;
   logic [PC_W-1:0] update_pc, wb_addr;
`ifdef BPQ_STATS_EN
   logic [15:0] wr_count, evict_count;
`endif
   bp_update_queue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_taken(in_taken), .in_target(in_target),
      .we(we), .update_pc(update_pc), .branch_taken(branch_taken),
      .wb_addr(wb_addr), .evict(evict), .empty(empty)
`ifdef BPQ_STATS_EN
      , .wr_count(wr_count), .evict_count(evict_count)
`endif
   );
   always #5 clk = ~clk;

   typedef struct {logic [PC_W-1:0] pc; logic tk; logic [PC_W-1:0] tgt;} ent_t;
   typedef struct {
      logic v; logic [PC_W-1:0] pc; logic tk; logic [PC_W-1:0] tgt; logic ev;
      logic x_we; logic [PC_W-1:0] x_pc; logic x_tk; logic [PC_W-1:0] x_tgt; logic x_rdy; logic x_emp;
   } vec_t;

   int total = 0, bad = 0;
   ent_t q[$];
   ent_t m_out;
   logic m_we, m_bub;
   int m_wr, m_ev;

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_we = 0; m_bub = 0; m_wr = 0; m_ev = 0;
      m_out = '{'0, 1'b0, '0};
   endtask

   // One clock: model advances with the pre-edge inputs, outputs compared at the falling edge.
   task automatic tick();
      bit pop, push;
      ent_t e;
      pop  = q.size() > 0 && !(m_we && evict);
      push = in_valid && q.size() < DEPTH;
      e = '{in_pc, in_taken, in_target};
      @(posedge clk);
      if (m_we && m_wr < 65535) m_wr++;
      if (m_we && evict && m_ev < 65535) m_ev++;
      m_bub = m_we && evict;
      m_we = pop;
      if (pop) m_out = q.pop_front();
      if (push) q.push_back(e);
      @(negedge clk);
      chk("we", we, m_we);
      chk("in_ready", in_ready, q.size() < DEPTH);
      chk("empty", empty, q.size() == 0 && !m_we && !m_bub);
      chk("update_pc", update_pc, m_out.pc);
      chk("branch_taken", branch_taken, m_out.tk);
      chk("wb_addr", wb_addr, m_out.tgt);
`ifdef BPQ_STATS_EN
      chk("wr_count", wr_count, m_wr);
      chk("evict_count", evict_count, m_ev);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 0; in_valid = 0; evict = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1;
      model_reset();
   endtask

   initial begin
      vec_t tbl[8];
      bit   full;
      int   n;
      tbl[0] = '{1, 10'h00F, 1, 10'h00A, 0,  0, 10'h000, 0, 10'h000, 1, 0};
      tbl[1] = '{0, 10'h000, 0, 10'h000, 0,  1, 10'h00F, 1, 10'h00A, 1, 0};
      tbl[2] = '{0, 10'h000, 0, 10'h000, 0,  0, 10'h00F, 1, 10'h00A, 1, 1};
      tbl[3] = '{1, 10'h101, 0, 10'h201, 0,  0, 10'h00F, 1, 10'h00A, 1, 0};
      tbl[4] = '{1, 10'h102, 1, 10'h202, 0,  1, 10'h101, 0, 10'h201, 1, 0};
      tbl[5] = '{0, 10'h000, 0, 10'h000, 1,  0, 10'h101, 0, 10'h201, 1, 0};
      tbl[6] = '{0, 10'h000, 0, 10'h000, 0,  1, 10'h102, 1, 10'h202, 1, 0};
      tbl[7] = '{0, 10'h000, 0, 10'h000, 0,  0, 10'h102, 1, 10'h202, 1, 1};
      model_reset();
      #12;
      chk("reset we", we, 0);
      chk("reset update_pc", update_pc, 0);
      chk("reset wb_addr", wb_addr, 0);
      chk("reset in_ready", in_ready, 1);
      chk("reset empty", empty, 1);
      @(negedge clk);
      rst = 1;

      foreach (tbl[i]) begin
         in_valid = tbl[i].v; in_pc = tbl[i].pc; in_taken = tbl[i].tk;
         in_target = tbl[i].tgt; evict = tbl[i].ev;
         tick();
         chk($sformatf("vec%0d we", i), we, tbl[i].x_we);
         chk($sformatf("vec%0d update_pc", i), update_pc, tbl[i].x_pc);
         chk($sformatf("vec%0d branch_taken", i), branch_taken, tbl[i].x_tk);
         chk($sformatf("vec%0d wb_addr", i), wb_addr, tbl[i].x_tgt);
         chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].x_rdy);
         chk($sformatf("vec%0d empty", i), empty, tbl[i].x_emp);
      end

      // streaming push and drain, pointers wrap past DEPTH
      for (int i = 0; i < 10; i++) begin
         in_valid = 1; in_pc = 10'(i); in_taken = i[0]; in_target = 10'(i + 100); evict = 0;
         tick();
         if (i > 0) begin
            chk("stream we", we, 1);
            chk("stream order", update_pc, i - 1);
         end
      end
      in_valid = 0;
      tick();
      chk("stream last", update_pc, 9);
      chk("stream last tgt", wb_addr, 109);
      tick();
      chk("stream empty", empty, 1);

      // evictions stall the drain until the queue fills
      full = 0;
      for (int i = 0; i < 12 && !full; i++) begin
         in_valid = 1; in_pc = 10'(12'h300 + i); evict = 1;
         tick();
         full = !in_ready;
      end
      chk("fill reaches full", full, 1);
      in_valid = 0; evict = 0;
      n = 0;
      while (!empty && n < 12) begin tick(); n++; end
      chk("drain after full", empty, 1);
      chk("ready after drain", in_ready, 1);

      // asynchronous reset while writing with entries queued
      n = 0;
      while (!(q.size() >= 3 && m_we) && n < 12) begin
         in_valid = 1; in_pc = 10'(12'h200 + n); evict = 1;
         tick(); n++;
      end
      chk("reset setup reached", q.size() >= 3 && m_we, 1);
      in_valid = 0; evict = 0;
      #2 rst = 0;
      #1;
      chk("async reset drops we", we, 0);
      chk("async reset empty", empty, 1);
      chk("async reset in_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      rst = 1;
      model_reset();
      for (int i = 0; i < 6; i++) tick();

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         in_valid = $urandom_range(0, 99) < 60;
         in_pc = 10'($urandom); in_taken = 1'($urandom); in_target = 10'($urandom);
         evict = $urandom_range(0, 2) == 0;
         tick();
      end
      in_valid = 0; evict = 0;
      for (int i = 0; i < 8; i++) tick();
      chk("random drained", empty, 1);

`ifdef BPQ_STATS_EN
      do_reset();
      begin
         int pushed = 0, nev = 0;
         for (int i = 0; i < 30; i++) begin
            in_valid = pushed < 5;
            in_pc = 10'(i); in_target = 10'(i);
            evict = m_we && nev < 2;
            if (evict) nev++;
            if (in_valid && q.size() < DEPTH) pushed++;
            tick();
         end
      end
      chk("stats wr_count", wr_count, 5);
      chk("stats evict_count", evict_count, 2);
`else
      do_reset();
      tick();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
